// File: rtl/barrel_pkg.sv
// Shared types and constants for the 4-bit barrel shifter command path.
// Used by shift_cmd_issuer and its FIFOs.
package barrel_pkg;

    localparam int DATA_W  = 4;
    localparam int SHIFT_W = 2;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    // One shift command as stored in the command FIFO (7 bits).
    typedef struct packed {
        logic [DATA_W-1:0]  data;
        logic [SHIFT_W-1:0] shift;
        logic               dir;
    } shift_cmd_t;

    localparam int CMD_W = $bits(shift_cmd_t);

    // Statistics counters stop at all-ones instead of wrapping.
    localparam int          STAT_W   = 16;
    localparam logic [15:0] STAT_MAX = 16'hFFFF;

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        if (v == STAT_MAX) begin
            return v;
        end
        return v + 16'd1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count.
// Pushes while full and pops while empty are ignored, so callers may gate
// with full/empty or rely on this guard. DEPTH need not be a power of two:
// the pointers wrap explicitly at DEPTH-1.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == LAST_PTR) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; simultaneous push and pop leave count unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage array; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/shift_cmd_issuer.sv
// Command stage in front of the 4-bit barrel shifter.
// Buffers incoming shift commands, issues at most one per cycle to the
// shifter's registered inputs, captures the shifter's registered result two
// edges after issue, and presents results in order on a valid/ready output.
// Issue is credit-limited so the result buffer can never overflow.
// Optional macro SHIFT_CMD_STATS_EN adds saturating issue/stall counters.
module shift_cmd_issuer
    import barrel_pkg::*;
#(
    parameter int CMD_DEPTH = 4,
    parameter int RES_DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_data,
    input  logic [SHIFT_W-1:0] in_shift,
    input  logic               in_dir,
    output logic [DATA_W-1:0]  sh_data,
    output logic [SHIFT_W-1:0] sh_shift,
    output logic               sh_dir,
    output logic               sh_issue,
    input  logic [DATA_W-1:0]  sh_result,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_result,
    output logic               busy
`ifdef SHIFT_CMD_STATS_EN
    ,
    output logic [STAT_W-1:0]  stat_issued,
    output logic [STAT_W-1:0]  stat_stall
`endif
);

    // Handshakes: a transfer happens on a rising edge where valid && ready.
    // Valid never waits for ready; once raised, valid and its payload hold
    // until the transfer. in_ready depends only on command FIFO fullness and
    // out_valid only on result buffer occupancy, never on the partner's signal.

    localparam int CMD_CNT_W = $clog2(CMD_DEPTH + 1);
    localparam int RES_CNT_W = $clog2(RES_DEPTH + 1);
    localparam int CREDIT_W  = RES_CNT_W + 2;

    localparam logic [CREDIT_W-1:0] CREDIT_LIMIT = CREDIT_W'(RES_DEPTH);

    // Reject illegal depth configurations at elaboration.
    if ((CMD_DEPTH < 2) || ((CMD_DEPTH & (CMD_DEPTH - 1)) != 0)) begin : g_bad_cmd_depth
        $error("CMD_DEPTH must be a power of two and at least 2");
    end
    if (RES_DEPTH < 2) begin : g_bad_res_depth
        $error("RES_DEPTH must be at least 2");
    end

    shift_cmd_t            in_cmd;
    shift_cmd_t            cmd_head;
    logic                  cmd_push;
    logic                  cmd_full;
    logic                  cmd_empty;
    logic [CMD_CNT_W-1:0]  cmd_count;

    logic                  res_push;
    logic                  res_pop;
    logic                  res_full;
    logic                  res_empty;
    logic [RES_CNT_W-1:0]  res_count;
    logic [DATA_W-1:0]     res_head;

    // pend marks the cycle in which the shifter's output register holds the
    // result of the command issued two edges earlier.
    logic                  pend;
    logic [CREDIT_W-1:0]   credit_used;
    logic                  credit_ok;
    logic                  issue;

    assign in_cmd = '{data: in_data, shift: in_shift, dir: in_dir};

    assign in_ready = !cmd_full;
    assign cmd_push = in_valid && in_ready;

    // A result slot is reserved for every buffered result plus every command
    // still travelling through the shifter. Slots freed by an output pop on
    // this edge only become usable on the next one.
    assign credit_used = CREDIT_W'(res_count) + CREDIT_W'(sh_issue) + CREDIT_W'(pend);
    assign credit_ok   = (credit_used < CREDIT_LIMIT);
    assign issue       = !cmd_empty && credit_ok;

    // The credit rule keeps the buffer from being full when pend is high;
    // the full guard only protects against misuse of the parameters.
    assign res_push = pend && !res_full;
    assign res_pop  = out_valid && out_ready;

    assign out_valid  = !res_empty;
    assign out_result = res_head;

    assign busy = (cmd_count != '0) || sh_issue || pend || !res_empty;

    sync_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (CMD_DEPTH)
    ) u_cmd_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (cmd_push),
        .wdata (in_cmd),
        .pop   (issue),
        .rdata (cmd_head),
        .full  (cmd_full),
        .empty (cmd_empty),
        .count (cmd_count)
    );

    sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (RES_DEPTH)
    ) u_res_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (res_push),
        .wdata (sh_result),
        .pop   (res_pop),
        .rdata (res_head),
        .full  (res_full),
        .empty (res_empty),
        .count (res_count)
    );

    // Shifter drive registers and the capture-timing pipeline; sh_* hold
    // their last command when nothing is issued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_data  <= '0;
            sh_shift <= '0;
            sh_dir   <= DIR_LEFT;
            sh_issue <= 1'b0;
            pend     <= 1'b0;
        end else begin
            sh_issue <= issue;
            pend     <= sh_issue;
            if (issue) begin
                sh_data  <= cmd_head.data;
                sh_shift <= cmd_head.shift;
                sh_dir   <= cmd_head.dir;
            end
        end
    end

`ifdef SHIFT_CMD_STATS_EN
    logic stall;

    assign stall = !cmd_empty && !credit_ok;

    // Saturating counts of issued commands and of cycles blocked by credit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_issued <= '0;
            stat_stall  <= '0;
        end else begin
            if (issue) begin
                stat_issued <= sat_inc(stat_issued);
            end
            if (stall) begin
                stat_stall <= sat_inc(stat_stall);
            end
        end
    end
`endif

endmodule
